mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the pipeline's instruction-fetch side (I, read-only) and data side (D, load/store).
- Sits between IF/MEM stage memory requests and the external memory request/response channel.
- Produces per-side acknowledges; the pipeline stalls while req && !ack.
- D has fixed priority over I, with a starvation guard that forces an I grant after STARVE_MAX consecutive D grants.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced (>=1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_WIDTH  fetch address
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  DATA_WIDTH  fetch data, valid when i_ack
- d_req  in  1  data request; held with payload until d_ack
- d_we  in  1  1 = store, 0 = load
- d_strb  in  DATA_WIDTH/8  byte strobes for stores
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_ack  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  DATA_WIDTH  load data, valid when d_ack
- m_valid  out  1  memory request valid
- m_ready  in  1  memory accepts request
- m_we, m_strb, m_addr, m_wdata  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  registered request payload
- m_rvalid  in  1  response valid (also signals store completion)
- m_rdata  in  DATA_WIDTH  response data
- protocol_err  out  1  sticky flag: m_rvalid received outside WAIT

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE, owner=I, starve_cnt=0, protocol_err=0.
  - m_valid=0; m_we/m_strb/m_addr/m_wdata=0.
  - i_ack=d_ack=0.
- Mid-operation reset drops the transaction; any later stray m_rvalid sets protocol_err.
- States:
  - IDLE: arbitrate. Grant D if d_req && !(i_req && starve_cnt==STARVE_MAX); otherwise grant I if i_req. On grant, latch payload into m_* regs, record owner, go to ISSUE. No request: stay in IDLE.
  - ISSUE: m_valid=1 and payload stable until m_valid && m_ready; then go to WAIT with m_valid=0 from the next cycle.
  - WAIT: on m_rvalid, assert the owner's ack combinationally that cycle, drive its rdata = m_rdata (pass-through), return to IDLE at the next edge.
- I requests drive m_we=0, m_strb=all ones, m_wdata=0.
- Unowned rdata output holds its last value; it is don't-care when its ack is low.
- Starvation counter:
  - On a D grant with i_req=1: starve_cnt increments, saturating at STARVE_MAX.
  - On an I grant, or a D grant with i_req=0: starve_cnt clears.
- Timing:
  - Minimum req-to-ack with m_ready=1 and response next cycle: grant at edge 0, ISSUE cycle 1, WAIT cycle 2, ack in cycle 2.
  - One IDLE bubble separates consecutive transactions.
- Requester rules:
  - Requester holds req and payload until ack.
  - At the ack edge, the requester may drop req or present a new request. IDLE samples req only after the ack cycle, so a held req is treated as a new request.
- Simultaneous i_req and d_req in IDLE: the priority rule above applies. The losing side stays pending and simply sees no ack.
- m_rvalid in IDLE or ISSUE: ignored (no ack), protocol_err set until reset.
- m_ready asserted while not in ISSUE: ignored.

Decomposition:
- Shared header (SYSTEM_DEF.vh) holds:
  - state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2
  - owner encodings ARB_OWN_I=1'b0, ARB_OWN_D=1'b1
- Natural sub-module: arb_starve_ctr, containing the saturating counter plus the grant decision (inputs i_req, d_req, grant_en; outputs grant_i, grant_d).
- FSM and payload registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100, m_ready=1, m_rvalid one cycle after accept with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, i_ack in cycle 2, i_rdata=0x00500093, d_ack never asserted.
- Simultaneous requests: i_req and d_req (load, 0x2000) in the same cycle -> D served first, d_ack, one IDLE bubble, then I issued and i_ack; exactly one m_valid handshake per transaction.
- Starvation: d_req held continuously with back-to-back acks, i_req=1, STARVE_MAX=4 -> four D grants, fifth grant goes to I, starve_cnt returns to 0, then D resumes.
- Store with backpressure: d_we=1, d_strb=4'b0011, d_wdata=0xDEADBEEF, m_ready low 3 cycles -> m_valid high 3+ cycles with stable payload, d_ack on m_rvalid, no i_ack.
- Reset mid-WAIT: aresetn low while in WAIT -> immediate m_valid=0, acks 0; later stray m_rvalid -> no ack, protocol_err=1 held until next reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-ported memory arbiter: FSM state codes,
// owner codes and a helper for sizing the starvation counter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam logic ARB_OWN_I = 1'b0;
  localparam logic ARB_OWN_D = 1'b1;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Grant decision for the memory arbiter: D has fixed priority, but I is forced
// through once D has won STARVE_MAX times in a row while I was waiting.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_i,
  output logic grant_d
);

  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             i_forced;

  assign i_forced = i_req && (starve_cnt == CNT_MAX);
  assign grant_d  = grant_en && d_req && !i_forced;
  assign grant_i  = grant_en && i_req && !grant_d;

  // Counts consecutive D wins only while I is actually waiting.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
    end else if (grant_i || grant_d) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and data (D);
// one outstanding transaction at a time, acks pass the response straight through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_strb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_we,
  output logic [DATA_WIDTH/8-1:0] m_strb,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    protocol_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0]            state;
  logic                  owner;
  logic                  grant_en;
  logic                  grant_i;
  logic                  grant_d;
  logic                  rsp_fire;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  assign grant_en = (state == ARB_IDLE);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_req    (i_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  assign m_valid  = (state == ARB_ISSUE);
  assign rsp_fire = (state == ARB_WAIT) && m_rvalid;
  assign i_ack    = rsp_fire && (owner == ARB_OWN_I);
  assign d_ack    = rsp_fire && (owner == ARB_OWN_D);

  // Response data is passed through on the ack cycle and held afterwards.
  assign i_rdata = i_ack ? m_rdata : i_rdata_q;
  assign d_rdata = d_ack ? m_rdata : d_rdata_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ARB_IDLE;
      owner   <= ARB_OWN_I;
      m_we    <= 1'b0;
      m_strb  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            owner   <= ARB_OWN_D;
            m_we    <= d_we;
            m_strb  <= d_strb;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= ARB_ISSUE;
          end else if (grant_i) begin
            owner   <= ARB_OWN_I;
            m_we    <= 1'b0;
            m_strb  <= {STRB_WIDTH{1'b1}};
            m_addr  <= i_addr;
            m_wdata <= '0;
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (m_ready) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (m_rvalid) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ack) i_rdata_q <= m_rdata;
      if (d_ack) d_rdata_q <= m_rdata;
    end
  end

  // A response with nothing outstanding means requester and memory disagree.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      protocol_err <= 1'b0;
    end else if (m_rvalid && (state != ARB_WAIT)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        aclk;
  logic        aresetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_strb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_ready;
  logic        m_we;
  logic [3:0]  m_strb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        protocol_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: D wins in a row while I waited, last delivered data per side.
  int          streak;
  logic [31:0] last_i_data, last_d_data;
  logic        seen_i, seen_d;
  logic        exp_perr;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_strb       (d_strb),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_we         (m_we),
    .m_strb       (m_strb),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .protocol_err (protocol_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] %s differs from reference", tag);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                               input logic [3:0] strb, input logic [31:0] da, input logic [31:0] dw);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = we;
    d_strb  = strb;
    d_addr  = da;
    d_wdata = dw;
  endtask

  task automatic modelReset();
    streak   = 0;
    seen_i   = 1'b0;
    seen_d   = 1'b0;
    exp_perr = 1'b0;
  endtask

  // One complete transaction starting from an IDLE cycle with requests set.
  task automatic runTxn(input int ready_delay, input int rsp_delay, input logic [31:0] rdata);
    logic        win_d;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_addr, exp_wdata;
    win_d = d_req && !(i_req && streak == STARVE_MAX);
    if (win_d) begin
      exp_we = d_we; exp_strb = d_strb; exp_addr = d_addr; exp_wdata = d_wdata;
    end else begin
      exp_we = 1'b0; exp_strb = 4'hF; exp_addr = i_addr; exp_wdata = 32'h0;
    end
    @(posedge aclk); #1;
    m_ready = (ready_delay == 0);
    for (int k = 0; k <= ready_delay; k++) begin
      @(negedge aclk);
      checkOutput("issue_m_valid", m_valid, 1);
      checkOutput("issue_m_addr", m_addr, exp_addr);
      checkOutput("issue_m_we", m_we, exp_we);
      checkOutput("issue_m_strb", m_strb, exp_strb);
      checkOutput("issue_m_wdata", m_wdata, exp_wdata);
      checkOutput("issue_acks", {i_ack, d_ack}, 0);
      @(posedge aclk); #1;
      if (k + 1 == ready_delay) m_ready = 1'b1;
    end
    m_ready = 1'b0;
    for (int r = 0; r < rsp_delay; r++) begin
      @(negedge aclk);
      checkOutput("wait_m_valid", m_valid, 0);
      checkOutput("wait_acks", {i_ack, d_ack}, 0);
      @(posedge aclk); #1;
    end
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    @(negedge aclk);
    checkOutput("rsp_m_valid", m_valid, 0);
    checkOutput("rsp_i_ack", i_ack, !win_d);
    checkOutput("rsp_d_ack", d_ack, win_d);
    if (win_d) begin
      checkOutput("rsp_d_rdata", d_rdata, rdata);
      if (seen_i) checkOutput("hold_i_rdata", i_rdata, last_i_data);
    end else begin
      checkOutput("rsp_i_rdata", i_rdata, rdata);
      if (seen_d) checkOutput("hold_d_rdata", d_rdata, last_d_data);
    end
    checkOutput("rsp_protocol_err", protocol_err, exp_perr);
    if (win_d && i_req) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
    else streak = 0;
    if (win_d) begin last_d_data = rdata; seen_d = 1'b1; end
    else begin last_i_data = rdata; seen_i = 1'b1; end
    @(posedge aclk); #1;
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    if (win_d) d_req = 1'b0;
    else i_req = 1'b0;
    @(negedge aclk);
    checkOutput("bubble_m_valid", m_valid, 0);
    checkOutput("bubble_acks", {i_ack, d_ack}, 0);
  endtask

  initial begin
    aresetn  = 1'b0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    modelReset();

    // Reset state
    #12;
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_payload", {m_we, m_strb, m_addr, m_wdata}, 0);
    checkOutput("reset_acks", {i_ack, d_ack}, 0);
    checkOutput("reset_protocol_err", protocol_err, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);

    // Lone fetch
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    runTxn(0, 0, 32'h00500093);

    // Simultaneous requests: D first, then the waiting I
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    runTxn(0, 0, 32'hA5A5_0001);
    runTxn(0, 0, 32'hA5A5_0002);

    // Starvation guard: D re-requests after every ack, I stays pending
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
    for (int n = 0; n < 11; n++) begin
      runTxn(0, 0, 32'h5000_0000 + 32'(n));
      if (!d_req) begin d_req = 1'b1; d_addr = d_addr + 32'h4; end
      if (!i_req) begin i_req = 1'b1; i_addr = i_addr + 32'h4; end
    end
    runTxn(0, 0, 32'h5000_00FF);
    runTxn(1, 1, 32'h5000_01FF);

    // Store with three cycles of backpressure
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h4000, 32'hDEADBEEF);
    runTxn(3, 0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_req && ($urandom_range(0, 1) == 1)) begin
        i_req  = 1'b1;
        i_addr = {$urandom_range(0, 65535), 2'b00};
      end
      if (!d_req && ($urandom_range(0, 1) == 1)) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_strb  = 4'($urandom);
        d_addr  = {$urandom_range(0, 65535), 2'b00};
        d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin
        i_req  = 1'b1;
        i_addr = {$urandom_range(0, 65535), 2'b00};
      end
      runTxn($urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge aclk);

    // Reset while WAIT, then a stray response
    i_req  = 1'b1;
    i_addr = 32'h400;
    @(posedge aclk); #1;
    m_ready = 1'b1;
    @(posedge aclk); #1;
    m_ready = 1'b0;
    @(negedge aclk);
    checkOutput("wait_before_reset_m_valid", m_valid, 0);
    #1;
    aresetn  = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 32'h1234_5678;
    i_req    = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_acks", {i_ack, d_ack}, 0);
    checkOutput("midreset_m_valid", m_valid, 0);
    checkOutput("midreset_m_addr", m_addr, 0);
    checkOutput("midreset_protocol_err", protocol_err, 0);
    m_rvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("post_reset_protocol_err", protocol_err, 0);
    @(posedge aclk); #1;
    m_rvalid = 1'b1;
    @(negedge aclk);
    checkOutput("stray_acks", {i_ack, d_ack}, 0);
    @(posedge aclk); #1;
    m_rvalid = 1'b0;
    exp_perr = 1'b1;
    @(negedge aclk);
    checkOutput("stray_protocol_err", protocol_err, 1);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("sticky_protocol_err", protocol_err, 1);
    @(negedge aclk);

    // Still functional with the error flag set; reset then clears it
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    runTxn(0, 1, 32'hCAFE_F00D);
    aresetn = 1'b0;
    #1;
    checkOutput("final_reset_protocol_err", protocol_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
